mem_access_ctrl: RTL
====================

# mem_access_ctrl

Sequences and shares the 512x8 byte-addressed data RAM between the instruction-fetch requester and the load/store requester. Arbitrates round-robin, drives the RAM's MOV/MOC handshake with a guaranteed MOV low gap between accesses, and splits doubleword accesses into two 32-bit RAM phases (DMOC-tracked). Sits between the CPU control unit and the RAM, replacing direct control-unit drive of MOV/ReadWrite/Address/OpCode/DataIn.

## Interface
- TIMEOUT, 15: maximum WAIT cycles for MOC per phase before the access is aborted with an error (range 2..255).
- Clk  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- IReq  in  1  fetch request, level; held until IReady.
- IAddr  in  9  fetch byte address.
- IReady  out  1  one-cycle pulse; IData valid this cycle.
- IData  out  32  fetched word; holds until next fetch completes.
- DReq  in  1  load/store request, level; held until DReady.
- DReadWrite  in  1  1=read, 0=write.
- DOpCode  in  6  MIPS load/store opcode.
- DAddr  in  9  byte address.
- DWrData  in  64  write data; [31:0] for byte/half/word, [63:32] first then [31:0] for doubleword.
- DReady  out  1  one-cycle pulse; DRdData valid this cycle.
- DRdData  out  64  read data; [31:0] for 32-bit-or-less reads, {first,second} for doubleword.
- Err  out  1  valid only with IReady/DReady; 1 = access failed.
- Busy  out  1  1 in any state other than IDLE.
- MOV, ReadWrite  out  1 each  RAM handshake/direction.
- Address  out  9;  OpCode  out  6;  DataIn  out  32  RAM request fields.
- DataOut  in  32;  MOC  in  1;  DMOC  in  1  RAM response.

## Operation
- States: IDLE, ISSUE, WAIT, GAP, DONE.
- IDLE: if any Req, grant; latch requester id, address, opcode, direction, DWrData; phase←0. Tie: grant the port not granted last (after reset D wins first tie). Fetch uses OpCode 100011, ReadWrite 1.
- Legal D opcodes: reads 110101,100011,100101,100001,100100,100000 (DReadWrite must be 1); writes 111111,101011,101001,101000 (DReadWrite must be 0). Illegal or direction mismatch → no MOV; go straight to DONE with Err=1.
- Doubleword (110101/111111): if DMOC=1 at grant, RAM is out of phase → DONE with Err=1, no MOV.
- ISSUE: MOV=1, fields driven; MOC not sampled (stale from previous op). → WAIT.
- WAIT: MOV=1; timer increments each cycle. MOC=1 → capture DataOut (reads: phase0 into [63:32] for dw else [31:0]; phase1 into [31:0]), MOV←0, → GAP. Timer reaches TIMEOUT without MOC → MOV←0, error flag set, → GAP.
- GAP: MOV=0 one cycle. Doubleword, phase0, no error → phase←1, DataIn←DWrData[31:0], → ISSUE. Else → DONE.
- DONE: pulse the granted port's Ready with Err; update IData or DRdData (reads only, not on error). → IDLE.
- Req dropped mid-access: access still completes; Ready pulse still issued.
- Address/OpCode/ReadWrite/DataIn held stable from ISSUE through GAP.

## Timing
- Reset values: MOV 0, ReadWrite 1, Address 0, OpCode 0, DataIn 0, IReady 0, DReady 0, Err 0, IData 0, DRdData 0, Busy 0; state IDLE; last-grant = I.
- Request sampled at edge E0; single-phase access with MOC on first WAIT cycle: ISSUE E0–E1, WAIT E1–E2, GAP E2–E3, Ready high E3–E4, IDLE at E4. Latency 4 cycles; throughput 1 access per 5 cycles.
- Doubleword: Ready high E6–E7 (7 cycles).
- MOV is low for at least 2 consecutive cycles (GAP + IDLE/DONE) between independent accesses, 1 cycle between doubleword phases; every access therefore produces a fresh MOV rising edge.
- Error-rejected (no-MOV) access: Ready with Err one cycle after grant.
- Reset mid-access: next cycle everything at reset values, MOV 0; RAM DMOC may remain 1, which the next doubleword reports as Err (software re-syncs).

## Test plan
- Fetch IAddr=0x010, RAM bytes 0x12,0x34,0x56,0x78 → IReady 4 cycles after request, IData=0x12345678, Err=0, MOV single pulse.
- IReq and DReq (lw 100011 @0x020) both raised same cycle after reset → D granted first, I granted in next IDLE; back-to-back pairs alternate.
- sd (111111) DAddr=0x040, DWrData=0x0123456789ABCDEF, then ld (110101) → two MOV pulses each, DRdData=0x0123456789ABCDEF, DMOC back to 0.
- MOC tied 0, TIMEOUT=15 → MOV drops after 15 WAIT cycles, DReady with Err=1, DRdData unchanged.
- DOpCode=101011 with DReadWrite=1 → no MOV, DReady+Err one cycle after grant; Reset asserted during WAIT → MOV 0 and Busy 0 next cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: round-robin arbiter and MOV/MOC sequencer sharing the 512x8 data RAM
// between instruction fetch and load/store, splitting doublewords into two 32-bit phases.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IReq,
    input  logic [8:0]  IAddr,
    output logic        IReady,
    output logic [31:0] IData,
    input  logic        DReq,
    input  logic        DReadWrite,
    input  logic [5:0]  DOpCode,
    input  logic [8:0]  DAddr,
    input  logic [63:0] DWrData,
    output logic        DReady,
    output logic [63:0] DRdData,
    output logic        Err,
    output logic        Busy,
    output logic        MOV,
    output logic        ReadWrite,
    output logic [8:0]  Address,
    output logic [5:0]  OpCode,
    output logic [31:0] DataIn,
    input  logic [31:0] DataOut,
    input  logic        MOC,
    input  logic        DMOC
);

    localparam logic [5:0] OP_LD  = 6'b110101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_SD  = 6'b111111;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE} state_t;
    state_t state, state_nxt;

    logic        last_grant_i, sel_d, dw, rd, phase, err_flag;
    logic [7:0]  timer;
    logic [31:0] wr_lo;
    logic [63:0] rdbuf;
    logic        grant_i, grant_d, reject, capture, expire, next_phase, finish;
    logic        d_fin, fin_err;

    function automatic logic op_legal(input logic [5:0] op, input logic rw);
        case (op)
            OP_LD, OP_LW, OP_LHU, OP_LH, OP_LBU, OP_LB: return rw;
            OP_SD, OP_SW, OP_SH, OP_SB:                 return !rw;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic op_dw(input logic [5:0] op);
        return (op == OP_LD) || (op == OP_SD);
    endfunction

    assign Busy    = (state != IDLE);
    assign d_fin   = reject | sel_d;
    assign fin_err = reject | err_flag;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        reject     = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        next_phase = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                // on a tie the port that was not served last wins
                if (DReq && (!IReq || last_grant_i)) grant_d = 1'b1;
                else if (IReq)                       grant_i = 1'b1;
                if (grant_d && (!op_legal(DOpCode, DReadWrite) || (op_dw(DOpCode) && DMOC))) begin
                    reject    = 1'b1;
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else if (grant_d || grant_i) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (MOC) begin
                    capture   = 1'b1;
                    state_nxt = GAP;
                end else if (timer == TMO_LAST) begin
                    expire    = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (dw && !phase && !err_flag) begin
                    next_phase = 1'b1;
                    state_nxt  = ISSUE;
                end else begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_grant_i <= 1'b1;
            sel_d        <= 1'b0;
            dw           <= 1'b0;
            rd           <= 1'b0;
            phase        <= 1'b0;
            err_flag     <= 1'b0;
            timer        <= '0;
            MOV          <= 1'b0;
            ReadWrite    <= 1'b1;
            Address      <= '0;
            OpCode       <= '0;
            DataIn       <= '0;
            IReady       <= 1'b0;
            DReady       <= 1'b0;
            Err          <= 1'b0;
            IData        <= '0;
            DRdData      <= '0;
        end else begin
            IReady <= 1'b0;
            DReady <= 1'b0;
            Err    <= 1'b0;
            if (grant_i || grant_d) begin
                last_grant_i <= grant_i;
                sel_d        <= grant_d;
                dw           <= grant_d && op_dw(DOpCode);
                rd           <= grant_i || DReadWrite;
                phase        <= 1'b0;
                err_flag     <= 1'b0;
                timer        <= '0;
                rdbuf        <= '0;
            end
            if ((grant_i || grant_d) && !reject) begin
                MOV       <= 1'b1;
                Address   <= grant_d ? DAddr : IAddr;
                OpCode    <= grant_d ? DOpCode : OP_LW;
                ReadWrite <= grant_i || DReadWrite;
                if (grant_d) begin
                    DataIn <= op_dw(DOpCode) ? DWrData[63:32] : DWrData[31:0];
                    wr_lo  <= DWrData[31:0];
                end
            end
            if (capture) begin
                MOV <= 1'b0;
                if (rd) begin
                    if (dw && !phase) rdbuf[63:32] <= DataOut;
                    else              rdbuf[31:0]  <= DataOut;
                end
            end else if (expire) begin
                MOV      <= 1'b0;
                err_flag <= 1'b1;
            end else if (state == WAIT) begin
                timer <= timer + 8'd1;
            end
            if (next_phase) begin
                phase  <= 1'b1;
                timer  <= '0;
                DataIn <= wr_lo;
                MOV    <= 1'b1;
            end
            if (finish) begin
                DReady <= d_fin;
                IReady <= !d_fin;
                Err    <= fin_err;
                if (!fin_err && rd) begin
                    if (sel_d) DRdData <= rdbuf;
                    else       IData   <= rdbuf[31:0];
                end
            end
        end
    end

endmodule
